// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, field widths and EX/MEM control-bit indices
package pipe_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_t;

  // Register-specifier width of rs/rt/rd fields
  localparam int REG_ADDR_W = 5;

  // Bit positions inside the EX/MEM CTR_bits vector; callers slice exmem_* from CTR_bitsout
  localparam int CTR_BRANCH   = 0;
  localparam int CTR_MEMREAD  = 1;
  localparam int CTR_MEMWRITE = 2;
  localparam int CTR_REGWRITE = 3;
  localparam int CTR_MEMTOREG = 4;
  localparam int CTR_W        = 5;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare for the ID stage
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  output logic                  lu
);

  // A load writing r0 never creates a dependency
  assign lu = idex_memread && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer; HAZARD_STATS_EN adds stall/flush counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  idex_memread,
  input  logic                  exmem_branch,
  input  logic                  exmem_zero,
  input  logic                  exmem_memread,
  input  logic                  exmem_memwrite,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_hold,
  output logic                  exmem_flush,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0]      lu_stall_cnt,
  output logic [CNT_W-1:0]      mem_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic                  mem_err
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  hz_state_t        state, next_state;
  logic [CNT_W-1:0] wait_cnt, next_cnt;
  logic             access, taken, lu;
  logic             frozen, resolve, req;

  assign access = exmem_memread | exmem_memwrite;
  assign taken  = exmem_branch & exmem_zero;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .lu           (lu)
  );

  // State and wait-counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  // Next state, wait counting, and whether this cycle is frozen or free to resolve branch/load-use
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    frozen     = 1'b0;
    resolve    = 1'b0;
    req        = 1'b0;
    case (state)
      ST_RUN: begin
        req = access;
        if (access && !mem_ready) begin
          frozen     = 1'b1;
          next_state = ST_MEM_WAIT;
          next_cnt   = CNT_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        req = 1'b1;
        if (mem_ready) begin
          resolve    = 1'b1;
          next_state = ST_RUN;
          next_cnt   = '0;
        end else begin
          frozen = 1'b1;
          if (wait_cnt != '1) next_cnt = wait_cnt + CNT_W'(1);
          if (wait_cnt == TMO_LAST) next_state = ST_ERROR;
        end
      end
      ST_ERROR: begin
        frozen = 1'b1;
      end
      default: begin
        frozen     = 1'b1;
        next_state = ST_RUN;
        next_cnt   = '0;
      end
    endcase
  end

  // Pipeline-register controls; reset forces the free-running PC/IF-ID pattern immediately
  always_comb begin
    mem_req     = 1'b0;
    pc_write    = 1'b1;
    pc_src      = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    exmem_flush = 1'b0;
    mem_err     = 1'b0;
    if (!reset) begin
      mem_req = req;
      mem_err = (state == ST_ERROR);
      if (frozen) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        exmem_hold = 1'b1;
      end else if (resolve && taken) begin
        pc_src      = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end else if (resolve && lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic lu_stall;
  assign lu_stall = idex_bubble & ~exmem_flush;

  // Saturating counters of load-use stalls, frozen cycles and taken-branch flushes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (lu_stall && lu_stall_cnt != '1)   lu_stall_cnt  <= lu_stall_cnt + CNT_W'(1);
      if (exmem_hold && mem_stall_cnt != '1) mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
      if (exmem_flush && flush_cnt != '1)   flush_cnt     <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ERR  = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       idex_memread, exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, mem_ready;
  logic       mem_req, pc_write, pc_src, ifid_write, ifid_flush, idex_bubble;
  logic       exmem_hold, exmem_flush, mem_err;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
  int m_lu_cnt, m_mem_cnt, m_flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_mode;
  int m_frozen;
  logic [8:0] outs;
  logic [8:0] e;

  // order: req pcw src ifw iff bub hold exf err
  assign outs = {mem_req, pc_write, pc_src, ifid_write, ifid_flush,
                 idex_bubble, exmem_hold, exmem_flush, mem_err};

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .idex_rt        (idex_rt),
    .idex_memread   (idex_memread),
    .exmem_branch   (exmem_branch),
    .exmem_zero     (exmem_zero),
    .exmem_memread  (exmem_memread),
    .exmem_memwrite (exmem_memwrite),
    .mem_ready      (mem_ready),
    .mem_req        (mem_req),
    .pc_write       (pc_write),
    .pc_src         (pc_src),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .exmem_hold     (exmem_hold),
    .exmem_flush    (exmem_flush),
`ifdef HAZARD_STATS_EN
    .lu_stall_cnt   (lu_stall_cnt),
    .mem_stall_cnt  (mem_stall_cnt),
    .flush_cnt      (flush_cnt),
`endif
    .mem_err        (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] exp_out();
    logic acc, tk, lu, req;
    acc = exmem_memread || exmem_memwrite;
    tk  = exmem_branch && exmem_zero;
    lu  = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (reset) return 9'b010100000;
    if (m_mode == M_ERR) return 9'b000000101;
    req = acc || (m_mode == M_WAIT);
    if (req && !mem_ready) return {1'b1, 8'b00000100};
    if (tk) return {req, 8'b11111010};
    if (lu) return {req, 8'b00001000};
    return {req, 8'b10100000};
  endfunction

  task automatic model_tick(input logic [8:0] ev);
    if (reset) begin
      m_mode   = M_RUN;
      m_frozen = 0;
`ifdef HAZARD_STATS_EN
      m_lu_cnt = 0; m_mem_cnt = 0; m_flush_cnt = 0;
`endif
      return;
    end
`ifdef HAZARD_STATS_EN
    if (ev[3] && !ev[1] && m_lu_cnt < SAT) m_lu_cnt++;
    if (ev[2] && m_mem_cnt < SAT) m_mem_cnt++;
    if (ev[1] && m_flush_cnt < SAT) m_flush_cnt++;
`endif
    if (m_mode == M_RUN) begin
      if ((exmem_memread || exmem_memwrite) && !mem_ready) begin
        m_mode   = M_WAIT;
        m_frozen = 1;
      end
    end else if (m_mode == M_WAIT) begin
      if (mem_ready) m_mode = M_RUN;
      else begin
        m_frozen++;
        if (m_frozen >= TMO) m_mode = M_ERR;
      end
    end
  endtask

  // settle and compare every output against the model
  task automatic eval(input string tag);
    #3;
    e = exp_out();
    check(tag, 32'(outs), 32'(e));
`ifdef HAZARD_STATS_EN
    check({tag, "_lucnt"}, 32'(lu_stall_cnt), 32'(m_lu_cnt));
    check({tag, "_memcnt"}, 32'(mem_stall_cnt), 32'(m_mem_cnt));
    check({tag, "_flcnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
`endif
  endtask

  task automatic tick();
    model_tick(exp_out());
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    ifid_rs = 5'd1; ifid_rt = 5'd2; idex_rt = 5'd3; idex_memread = 0;
    exmem_branch = 0; exmem_zero = 0; exmem_memread = 0; exmem_memwrite = 0; mem_ready = 0;
  endtask

  task automatic rand_inputs();
    ifid_rs        = 5'($urandom_range(0, 3));
    ifid_rt        = 5'($urandom_range(0, 3));
    idex_rt        = 5'($urandom_range(0, 3));
    idex_memread   = ($urandom_range(0, 1) == 1);
    exmem_branch   = ($urandom_range(0, 3) == 0);
    exmem_zero     = ($urandom_range(0, 1) == 1);
    exmem_memread  = ($urandom_range(0, 3) == 0);
    exmem_memwrite = ($urandom_range(0, 6) == 0);
    mem_ready      = ($urandom_range(0, 4) < 3);
  endtask

  // asynchronous reset asserted mid-cycle; outputs must drop to reset values before any edge
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_async"}, 32'(outs), 32'(9'b010100000));
    tick();
    reset = 1'b0;
  endtask

  initial begin
    m_mode = M_RUN;
    m_frozen = 0;
`ifdef HAZARD_STATS_EN
    m_lu_cnt = 0; m_mem_cnt = 0; m_flush_cnt = 0;
`endif
    reset = 1'b1;
    rand_inputs();
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      eval("reset_hold");
      tick();
    end
    reset = 1'b0;

    // load-use: one stall cycle, then the bubble removes the load
    quiet(); idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8;
    eval("lu");
    check("lu_pcw", 32'(pc_write), 0);
    check("lu_ifw", 32'(ifid_write), 0);
    check("lu_bub", 32'(idex_bubble), 1);
    tick();
    idex_memread = 0;
    eval("lu_after");
    check("lu_after_pcw", 32'(pc_write), 1);
    tick();

    // load into r0 never stalls
    quiet(); idex_memread = 1; idex_rt = 5'd0; ifid_rs = 5'd0;
    eval("lu_r0");
    check("lu_r0_pcw", 32'(pc_write), 1);
    tick();

    // taken branch overrides a concurrent load-use
    quiet(); idex_memread = 1; idex_rt = 5'd8; ifid_rt = 5'd8; exmem_branch = 1; exmem_zero = 1;
    eval("br");
    check("br_src", 32'(pc_src), 1);
    check("br_flushes", 32'({ifid_flush, idex_bubble, exmem_flush}), 32'(3'b111));
    check("br_pcw", 32'(pc_write), 1);
    tick();
    quiet();
    eval("br_after");
    check("br_after_src", 32'(pc_src), 0);
    tick();

    // three wait cycles, release on the fourth
    quiet(); exmem_memread = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      eval("mw");
      check("mw_req", 32'(mem_req), 1);
      check("mw_hold", 32'(exmem_hold), (i < 3) ? 1 : 0);
      tick();
    end
    quiet();
    eval("mw_done");
    check("mw_done_req", 32'(mem_req), 0);
    tick();

    // timeout into the sticky error state
    quiet(); exmem_memread = 1;
    for (int i = 0; i < TMO; i++) begin
      eval("tmo");
      check("tmo_req", 32'(mem_req), 1);
      check("tmo_err", 32'(mem_err), 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 1);
      eval("err");
      check("err_flag", 32'(mem_err), 1);
      check("err_req", 32'(mem_req), 0);
      tick();
    end
    quiet();
    eval("err_pre_rst");
    async_reset("err");
    eval("post_rst");
    check("post_rst_err", 32'(mem_err), 0);
    check("post_rst_pcw", 32'(pc_write), 1);
    tick();

`ifdef HAZARD_STATS_EN
    quiet();
    eval("sat_pre");
    async_reset("sat");
    quiet(); idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8;
    for (int i = 0; i < 300; i++) begin
      eval("sat");
      tick();
    end
    check("sat_lucnt", 32'(lu_stall_cnt), 32'(SAT));
`endif

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      eval("rnd");
      if ($urandom_range(0, 59) == 0) async_reset("rnd");
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
